// File: rtl/dmem_responder.sv
// Data-memory responder: word array with byte-lane stores and a fixed-latency
// load path that aligns, extends and error-checks each load before responding.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS  = 1024,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_rd_req,
   input  logic [31:0] i_rd_addr,
   input  logic [2:0]  i_rd_funct,
   output logic        o_rd_valid,
   output logic [31:0] o_rd_data,
   input  logic        i_wr_req,
   input  logic [31:0] i_wr_addr,
   input  logic [3:0]  i_wr_byte,
   input  logic [31:0] i_wr_data,
   output logic        o_busy,
   output logic        o_err
);

   localparam int unsigned AW       = $clog2(DEPTH_WORDS);
   localparam logic [2:0]  CNT_INIT = (READ_LATENCY >= 2) ? 3'(READ_LATENCY - 2) : 3'd0;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e        r_state;
   state_e        w_state_d;
   logic [2:0]    r_cnt;
   logic [2:0]    w_cnt_d;
   logic [31:0]   r_addr;
   logic [2:0]    r_funct;
   logic [31:0]   r_rd_data;
   logic          r_err;
   logic [31:0]   r_mem [DEPTH_WORDS];

   logic          w_accept;
   logic          w_enter_resp;
   logic [31:0]   w_ld_addr;
   logic [2:0]    w_ld_funct;
   logic [AW-1:0] w_ld_idx;
   logic [31:0]   w_ld_word;
   logic [31:0]   w_ld_shift;
   logic [31:0]   w_ld_data;
   logic          w_ld_err;
   logic          w_ld_oor;
   logic [AW-1:0] w_wr_idx;
   logic          w_wr_oor;
   logic          w_wr_en;
   logic          w_unused_wr_lsb;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= StIdle;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      unique case (r_state)
         StIdle: begin
            if (i_rd_req) begin
               if (READ_LATENCY == 1) begin
                  w_state_d = StResp;
               end else begin
                  w_state_d = StWait;
                  w_cnt_d   = CNT_INIT;
               end
            end
         end
         StWait: begin
            if (r_cnt == 3'd0) w_state_d = StResp;
            else               w_cnt_d   = r_cnt - 3'd1;
         end
         StResp:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      o_rd_valid = (r_state == StResp);
      o_busy     = (r_state != StIdle);
   end

   assign w_accept     = (r_state == StIdle) && i_rd_req;
   assign w_enter_resp = (w_state_d == StResp) && (r_state != StResp);

   // With a latency of 1 the response is formed on the accept edge itself
   assign w_ld_addr  = (r_state == StIdle) ? i_rd_addr : r_addr;
   assign w_ld_funct = (r_state == StIdle) ? i_rd_funct : r_funct;
   assign w_ld_idx   = w_ld_addr[AW+1:2];
   assign w_ld_oor   = |(w_ld_addr >> (AW + 2));
   assign w_ld_word  = r_mem[w_ld_idx];
   assign w_ld_shift = w_ld_word >> {w_ld_addr[1:0], 3'b000};

   always_comb begin
      w_ld_data = '0;
      w_ld_err  = 1'b0;
      case (w_ld_funct)
         3'b000: w_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
         3'b100: w_ld_data = {24'd0, w_ld_shift[7:0]};
         3'b001: begin
            w_ld_err  = w_ld_addr[0];
            w_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
         end
         3'b101: begin
            w_ld_err  = w_ld_addr[0];
            w_ld_data = {16'd0, w_ld_shift[15:0]};
         end
         3'b010: begin
            w_ld_err  = |w_ld_addr[1:0];
            w_ld_data = w_ld_word;
         end
         default: w_ld_err = 1'b1;
      endcase
      if (w_ld_oor) w_ld_err = 1'b1;
      if (w_ld_err) w_ld_data = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr    <= '0;
         r_funct   <= '0;
         r_rd_data <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_addr  <= i_rd_addr;
            r_funct <= i_rd_funct;
         end
         if (w_enter_resp) r_rd_data <= w_ld_data;
         r_err <= (w_enter_resp & w_ld_err) | (i_wr_req & w_wr_oor);
      end
   end

   assign o_rd_data = r_rd_data;
   assign o_err     = r_err;

   assign w_wr_idx        = i_wr_addr[AW+1:2];
   assign w_wr_oor        = |(i_wr_addr >> (AW + 2));
   assign w_wr_en         = i_wr_req & ~w_wr_oor & reset;
   assign w_unused_wr_lsb = ^i_wr_addr[1:0];

   // Array is deliberately not reset
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (i_wr_byte[i]) r_mem[w_wr_idx][8*i +: 8] <= i_wr_data[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: scoreboard of expected load responses
// (data, err, arrival cycle) plus direct checks of busy/err/reset behaviour.
module tb_dmem_responder;

   localparam int unsigned LAT = 2;

   logic        clk;
   logic        reset;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic [2:0]  rd_funct;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        wr_req;
   logic [31:0] wr_addr;
   logic [3:0]  wr_byte;
   logic [31:0] wr_data;
   logic        busy;
   logic        err;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;

   dmem_responder #(
      .DEPTH_WORDS (1024),
      .READ_LATENCY(LAT)
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .i_rd_req  (rd_req),
      .i_rd_addr (rd_addr),
      .i_rd_funct(rd_funct),
      .o_rd_valid(rd_valid),
      .o_rd_data (rd_data),
      .i_wr_req  (wr_req),
      .i_wr_addr (wr_addr),
      .i_wr_byte (wr_byte),
      .i_wr_data (wr_data),
      .o_busy    (busy),
      .o_err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every rd_valid must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rd_valid) begin
         if (sb.size() == 0) begin
            check_val("spurious_valid", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_val({e.tag, "_data"}, rd_data, e.data);
            check_val({e.tag, "_err"}, {31'd0, err}, {31'd0, e.err});
            check_val({e.tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic st(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                     input bit oor, input string tag);
      wr_req  = 1'b1;
      wr_addr = a;
      wr_byte = be;
      wr_data = d;
      tick();
      wr_req = 1'b0;
      check_val({tag, "_err"}, {31'd0, err}, {31'd0, oor});
      if (oor) begin
         tick();
         check_val({tag, "_err_clr"}, {31'd0, err}, 32'd0);
      end
   endtask

   task automatic ld_issue(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d,
                           input logic e, input string tag);
      exp_t x;
      rd_req   = 1'b1;
      rd_addr  = a;
      rd_funct = f;
      x.data   = d;
      x.err    = e;
      x.cyc    = cyc + LAT;
      x.tag    = tag;
      sb.push_back(x);
   endtask

   task automatic ld_wait(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         @(negedge clk);
         if (rd_valid) seen = 1'b1;
      end
      rd_req = 1'b0;
      if (!seen) check_val({tag, "_timeout"}, 32'd0, 32'd1);
      tick();
   endtask

   task automatic ld(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d,
                     input logic e, input string tag);
      ld_issue(a, f, d, e, tag);
      ld_wait(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset    = 1'b0;
      rd_req   = 1'b0;
      rd_addr  = '0;
      rd_funct = '0;
      wr_req   = 1'b0;
      wr_addr  = '0;
      wr_byte  = '0;
      wr_data  = '0;
      #3;
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_valid", {31'd0, rd_valid}, 32'd0);
      check_val("rst_data", rd_data, 32'd0);
      check_val("rst_err", {31'd0, err}, 32'd0);
      tick();
      tick();
      #2 reset = 1'b1;
      tick();

      st(32'h10, 4'b1111, 32'hDEADBEEF, 1'b0, "sw10");
      ld(32'h10, 3'b010, 32'hDEADBEEF, 1'b0, "lw10");
      ld(32'h13, 3'b000, 32'hFFFFFFDE, 1'b0, "lb13");
      ld(32'h13, 3'b100, 32'h000000DE, 1'b0, "lbu13");
      ld(32'h12, 3'b101, 32'h0000DEAD, 1'b0, "lhu12");
      ld(32'h10, 3'b001, 32'hFFFFBEEF, 1'b0, "lh10");
      ld(32'h11, 3'b100, 32'h000000BE, 1'b0, "lbu11");
      ld(32'h12, 3'b001, 32'hFFFFDEAD, 1'b0, "lh12");

      st(32'h10, 4'b0010, 32'h55555555, 1'b0, "sb11");
      ld(32'h10, 3'b010, 32'hDEAD55EF, 1'b0, "lw10_sb");
      st(32'h10, 4'b0000, 32'h12345678, 1'b0, "snone");
      ld(32'h10, 3'b010, 32'hDEAD55EF, 1'b0, "lw10_none");

      ld(32'h11, 3'b010, 32'h0, 1'b1, "lw_mis");
      ld(32'h13, 3'b001, 32'h0, 1'b1, "lh_mis");
      ld(32'h1000, 3'b010, 32'h0, 1'b1, "lw_oor");
      ld(32'h10, 3'b011, 32'h0, 1'b1, "bad_funct");
      ld(32'hFFFF_FFF0, 3'b100, 32'h0, 1'b1, "lbu_oor");

      // 0x1000 aliases word 0 in the index bits, so word 0 must stay intact
      st(32'h0, 4'b1111, 32'h01020304, 1'b0, "sw0");
      st(32'h1000, 4'b1111, 32'hFFFFFFFF, 1'b1, "sw_oor");
      ld(32'h0, 3'b010, 32'h01020304, 1'b0, "lw0");

      // Store on the edge entering RESP: load sees pre-store data
      st(32'h20, 4'b1111, 32'hCAFEF00D, 1'b0, "sw20");
      ld_issue(32'h20, 3'b010, 32'hCAFEF00D, 1'b0, "lw20_race");
      tick();
      st(32'h20, 4'b1111, 32'h0BADC0DE, 1'b0, "sw20_race");
      ld_wait("lw20_race");
      ld(32'h20, 3'b010, 32'h0BADC0DE, 1'b0, "lw20_new");
      tick();
      tick();
      check_val("hold_data", rd_data, 32'h0BADC0DE);
      check_val("hold_err", {31'd0, err}, 32'd0);

      // rd_req held across two loads; request changes in WAIT are ignored
      begin
         exp_t x;
         ld_issue(32'h10, 3'b010, 32'hDEAD55EF, 1'b0, "b2b_a");
         x.data = 32'h00000BAD;
         x.err  = 1'b0;
         x.cyc  = cyc + 5;
         x.tag  = "b2b_b";
         sb.push_back(x);
         tick();
         rd_addr  = 32'h22;
         rd_funct = 3'b101;
         @(negedge clk);
         check_val("b2b_busy1", {31'd0, busy}, 32'd1);
         @(negedge clk);
         check_val("b2b_busy2", {31'd0, busy}, 32'd1);
         @(negedge clk);
         check_val("b2b_busy3", {31'd0, busy}, 32'd0);
         @(negedge clk);
         check_val("b2b_busy4", {31'd0, busy}, 32'd1);
         @(negedge clk);
         check_val("b2b_valid5", {31'd0, rd_valid}, 32'd1);
         rd_req = 1'b0;
         tick();
      end

      // Reset during WAIT: load aborted, stores blocked, array retained
      rd_req   = 1'b1;
      rd_addr  = 32'h20;
      rd_funct = 3'b010;
      tick();
      check_val("abort_busy_pre", {31'd0, busy}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check_val("abort_busy", {31'd0, busy}, 32'd0);
      check_val("abort_valid", {31'd0, rd_valid}, 32'd0);
      check_val("abort_data", rd_data, 32'd0);
      rd_req  = 1'b0;
      wr_req  = 1'b1;
      wr_addr = 32'h10;
      wr_byte = 4'b1111;
      wr_data = 32'hFFFFFFFF;
      tick();
      tick();
      wr_req = 1'b0;
      #2 reset = 1'b1;
      tick();
      check_val("post_rst_busy", {31'd0, busy}, 32'd0);
      ld(32'h10, 3'b010, 32'hDEAD55EF, 1'b0, "lw_post_rst");
      tick();
      tick();

      check_val("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
